// File: rtl/ts_buffer_comb.sv
// Fixed-latency TS word delay line: DATA_OUT is DATA_IN delayed by DEPTH clock edges.
// Optional TS_BUFFER_PRIME_EN adds PRIMED, set once reset zeros have been flushed out.
`timescale 1ns/1ps

module ts_buffer_comb #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT
`ifdef TS_BUFFER_PRIME_EN
    ,
    output logic             PRIMED
`endif
);

    generate
        if (DEPTH > 16 || WIDTH < 1 || WIDTH > 64) begin : g_param_err
            $error("ts_buffer_comb: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
        end

        if (DEPTH == 0) begin : g_pass
            assign DATA_OUT = DATA_IN;

            // Clock and reset have no role in the zero-latency build.
            logic unused_clk_rst;
            assign unused_clk_rst = CLOCK ^ RESET;

`ifdef TS_BUFFER_PRIME_EN
            assign PRIMED = 1'b1;
`endif
        end else begin : g_delay
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q[0] <= DATA_IN;
                    for (int k = 1; k < int'(DEPTH); k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign DATA_OUT = stage_q[DEPTH-1];

`ifdef TS_BUFFER_PRIME_EN
            localparam int unsigned CntW = $clog2(DEPTH + 1);
            localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

            logic [CntW-1:0] cnt_d, cnt_q;

            // Saturates at DEPTH: by then every stage holds a captured word.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign PRIMED = (cnt_q == CntMax);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ts_buffer_comb.sv
// Directed bench for ts_buffer_comb: DEPTH=2 latency/stream/reset, DEPTH=0 pass-through,
// and PRIMED timing (DEPTH=2 and DEPTH=4) when TS_BUFFER_PRIME_EN is defined.
`timescale 1ns/1ps

module tb_ts_buffer_comb;

    logic       CLOCK;
    logic       RESET;
    logic [9:0] DATA_IN;
    logic [9:0] data_out2;
    logic [9:0] din0;
    logic [9:0] data_out0;
`ifdef TS_BUFFER_PRIME_EN
    logic       primed2;
    logic       primed0;
    logic [9:0] data_out4;
    logic       primed4;
`endif

    int total = 0;
    int bad   = 0;

    ts_buffer_comb #(.WIDTH(10), .DEPTH(2)) dut2 (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (data_out2)
`ifdef TS_BUFFER_PRIME_EN
        ,
        .PRIMED   (primed2)
`endif
    );

    ts_buffer_comb #(.WIDTH(10), .DEPTH(0)) dut0 (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .DATA_IN  (din0),
        .DATA_OUT (data_out0)
`ifdef TS_BUFFER_PRIME_EN
        ,
        .PRIMED   (primed0)
`endif
    );

`ifdef TS_BUFFER_PRIME_EN
    ts_buffer_comb #(.WIDTH(10), .DEPTH(4)) dut4 (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (data_out4),
        .PRIMED   (primed4)
    );
`endif

    // Rising edges at 5, 15, 25, ... ns.
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [9:0] words [6];
    logic [9:0] prev;

    initial begin
        words[0] = 10'h0CC;
        words[1] = 10'h337;
        words[2] = 10'h0E4;
        words[3] = 10'h3B1;
        words[4] = 10'h2CC;
        words[5] = 10'h353;

        // Reset hold.
        RESET   = 1'b1;
        DATA_IN = 10'h000;
        din0    = 10'h000;
        #2;  check("rst_hold_2ns", data_out2, 10'h000);
        #5;  check("rst_hold_7ns", data_out2, 10'h000);
`ifdef TS_BUFFER_PRIME_EN
        check("rst_primed2", {9'd0, primed2}, 10'h000);
        check("rst_primed4", {9'd0, primed4}, 10'h000);
        check("depth0_primed", {9'd0, primed0}, 10'h001);
`endif
        #3;  RESET = 1'b0;                                   // t=10
        #2;  check("lat_12ns", data_out2, 10'h000);
        #5;  check("lat_17ns", data_out2, 10'h000);
        #3;  DATA_IN = 10'h333;                              // t=20
        #2;  check("lat_22ns", data_out2, 10'h000);
`ifdef TS_BUFFER_PRIME_EN
        check("primed2_1edge", {9'd0, primed2}, 10'h000);
`endif
        #5;  check("lat_27ns", data_out2, 10'h000);
`ifdef TS_BUFFER_PRIME_EN
        check("primed2_2edges", {9'd0, primed2}, 10'h001);
`endif
        #5;  check("lat_32ns", data_out2, 10'h000);
        #5;  check("lat_37ns", data_out2, 10'h333);
`ifdef TS_BUFFER_PRIME_EN
        check("primed4_3edges", {9'd0, primed4}, 10'h000);
`endif
        #3;                                                  // t=40

        // Streaming: each word held two edges, must appear for exactly two edges.
        prev = 10'h333;
        for (int i = 0; i < 6; i++) begin
            DATA_IN = words[i];
            #7;  check("stream_first_half", data_out2, prev);
`ifdef TS_BUFFER_PRIME_EN
            if (i == 0) check("primed4_4edges", {9'd0, primed4}, 10'h001);
`endif
            #10; check("stream_second_half", data_out2, words[i]);
            #3;
            prev = words[i];
        end                                                  // t=160

        // Asynchronous reset while 0x337 sits in stage 0.
        DATA_IN = 10'h337;
        #7;  check("mid_before_rst", data_out2, 10'h353);   // t=167
        #1;  RESET = 1'b1;                                   // t=168, between edges
        #1;  check("mid_rst_async", data_out2, 10'h000);
`ifdef TS_BUFFER_PRIME_EN
        check("mid_rst_primed4", {9'd0, primed4}, 10'h000);
        check("mid_rst_primed2", {9'd0, primed2}, 10'h000);
`endif
        #2;  RESET = 1'b0;                                   // t=171
        DATA_IN = 10'h0E4;
        #1;  check("mid_after_release", data_out2, 10'h000);
        #5;  check("mid_no_replay", data_out2, 10'h000);    // t=177
        #10; check("mid_resume", data_out2, 10'h0E4);       // t=187
`ifdef TS_BUFFER_PRIME_EN
        check("mid_primed2_again", {9'd0, primed2}, 10'h001);
        #10; check("mid_primed4_3edges", {9'd0, primed4}, 10'h000);  // t=197
        #10; check("mid_primed4_4edges", {9'd0, primed4}, 10'h001);  // t=207
`endif

        // DEPTH=0 pass-through, reset high then low, changes mid-cycle.
        din0  = 10'h2CC;
        RESET = 1'b1;
        #1;  check("d0_rst_2cc", data_out0, 10'h2CC);
        #1;  din0 = 10'h353;
        #1;  check("d0_rst_353", data_out0, 10'h353);
        RESET = 1'b0;
        #1;  check("d0_run_353", data_out0, 10'h353);
        din0 = 10'h2CC;
        #1;  check("d0_run_2cc", data_out0, 10'h2CC);
        check("d0_run_depth2_cleared", data_out2, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
